// File: rtl/alu_pc_pkg.sv
// Shared types and constants for the ALU / next-PC unit.
// The optional overflow flag is controlled by the ALU_OVF_EN macro (see alu_core).
package alu_pc_pkg;

  localparam int unsigned DATA_W = 32;
  localparam logic [DATA_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLTU = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_STOP   = 2'b11
  } pc_inc_e;

  typedef enum logic [1:0] {
    BR_NONE  = 2'b00,
    BR_EQ    = 2'b01,
    BR_NE    = 2'b10,
    BR_NONE3 = 2'b11
  } branch_cond_e;

endpackage

// File: rtl/alu_core.sv
// Combinational 32-bit ALU: op, a, b -> result, zero, signed overflow.
// Overflow detection is only built when ALU_OVF_EN is defined; otherwise ovf is tied to 0.
import alu_pc_pkg::*;

module alu_core (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              ovf
);

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic        [DATA_W-1:0] sum;
  logic        [DATA_W-1:0] diff;
  logic        [4:0]        shamt;

  assign a_s   = a;
  assign b_s   = b;
  assign sum   = a + b;
  assign diff  = a - b;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = sum;
      OP_SUB:  result = diff;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_SRA:  result = a_s >>> shamt;
      OP_LUI:  result = {b[15:0], 16'h0000};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

`ifdef ALU_OVF_EN
  // Signed overflow: operands (b inverted for SUB) agree in sign but the result does not.
  always_comb begin
    ovf = 1'b0;
    case (op)
      OP_ADD:  ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1]  != a[DATA_W-1]);
      OP_SUB:  ovf = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      default: ovf = 1'b0;
    endcase
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/alu_pc_unit.sv
// Registered ALU plus next-PC selection (sequential / branch / jump / stop), one-cycle latency.
// Optional overflow flag built only with ALU_OVF_EN defined (inside alu_core).
import alu_pc_pkg::*;

module alu_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  branch_cond,
  input  logic [31:0] current_pc,
  input  logic [1:0]  pc_inc,
  input  logic [31:0] abs_addr,
  input  logic [31:0] branch_addr,
  output logic [31:0] alu_result,
  output logic        alu_zero,
  output logic        alu_ovf,
  output logic [31:0] next_pc,
  output logic [1:0]  pc_inc_q
);

  logic [31:0] res_p0;
  logic        zero_p0;
  logic        ovf_p0;
  logic        taken_p0;
  logic [31:0] pc_seq_p0;
  logic [31:0] pc_nxt_p0;

  alu_core u_alu (
    .op     (op),
    .a      (a),
    .b      (b),
    .result (res_p0),
    .zero   (zero_p0),
    .ovf    (ovf_p0)
  );

  assign taken_p0  = ((branch_cond == BR_EQ) &&  zero_p0) ||
                     ((branch_cond == BR_NE) && !zero_p0);
  assign pc_seq_p0 = current_pc + PC_STEP;

  // Word offset scaled to bytes; all additions wrap modulo 2^32.
  always_comb begin
    pc_nxt_p0 = pc_seq_p0;
    case (pc_inc)
      PC_SEQ:    pc_nxt_p0 = pc_seq_p0;
      PC_BRANCH: pc_nxt_p0 = taken_p0 ? (pc_seq_p0 + (branch_addr << 2)) : pc_seq_p0;
      PC_JUMP:   pc_nxt_p0 = abs_addr;
      PC_STOP:   pc_nxt_p0 = current_pc;
      default:   pc_nxt_p0 = pc_seq_p0;
    endcase
  end

  // Stage p0 -> outputs
  always_ff @(posedge clk) begin
    if (clr) begin
      alu_result <= '0;
      alu_zero   <= 1'b0;
      alu_ovf    <= 1'b0;
      next_pc    <= RESET_PC;
      pc_inc_q   <= 2'b00;
    end else begin
      alu_result <= res_p0;
      alu_zero   <= zero_p0;
      alu_ovf    <= ovf_p0;
      next_pc    <= pc_nxt_p0;
      pc_inc_q   <= pc_inc;
    end
  end

endmodule

// File: tb/tb_alu_pc_unit.sv
// Scoreboard bench for alu_pc_unit: expectations pushed when stimulus is driven, popped one cycle later.
// Overflow expectations follow ALU_OVF_EN.
import alu_pc_pkg::*;

module tb_alu_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
`ifdef ALU_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic [1:0]  branch_cond;
  logic [31:0] current_pc;
  logic [1:0]  pc_inc;
  logic [31:0] abs_addr, branch_addr;
  logic [31:0] alu_result;
  logic        alu_zero, alu_ovf;
  logic [31:0] next_pc;
  logic [1:0]  pc_inc_q;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic [31:0] pc;
    logic [1:0]  pinc;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  alu_pc_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .clr(clr), .op(op), .a(a), .b(b),
    .branch_cond(branch_cond), .current_pc(current_pc), .pc_inc(pc_inc),
    .abs_addr(abs_addr), .branch_addr(branch_addr),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .next_pc(next_pc), .pc_inc_q(pc_inc_q)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Independent reference model of one cycle of the unit.
  function automatic exp_t model(input logic [3:0] m_op, input logic [31:0] m_a, m_b,
                                 input logic [1:0] m_bc, input logic [31:0] m_cpc,
                                 input logic [1:0] m_pi, input logic [31:0] m_abs, m_off);
    exp_t   e;
    int     sh;
    longint wide;
    logic   tk;
    sh = int'(m_b[4:0]);
    case (m_op)
      4'd0:    e.res = m_a + m_b;
      4'd1:    e.res = m_a - m_b;
      4'd2:    e.res = m_a & m_b;
      4'd3:    e.res = m_a | m_b;
      4'd4:    e.res = m_a ^ m_b;
      4'd5:    e.res = ~(m_a | m_b);
      4'd6:    e.res = ($signed(m_a) < $signed(m_b)) ? 32'd1 : 32'd0;
      4'd7:    e.res = (m_a < m_b) ? 32'd1 : 32'd0;
      4'd8:    e.res = m_a << sh;
      4'd9:    e.res = m_a >> sh;
      4'd10:   e.res = 32'($signed(m_a) >>> sh);
      4'd11:   e.res = {m_b[15:0], 16'h0000};
      default: e.res = 32'd0;
    endcase
    e.zero = (e.res == 32'd0);
    wide = 0;
    if (m_op == 4'd0) wide = longint'($signed(m_a)) + longint'($signed(m_b));
    if (m_op == 4'd1) wide = longint'($signed(m_a)) - longint'($signed(m_b));
    e.ovf = OVF_ON && (wide > 64'sd2147483647 || wide < -64'sd2147483648);
    tk = (m_bc == 2'b01 && e.zero) || (m_bc == 2'b10 && !e.zero);
    case (m_pi)
      2'b00:   e.pc = m_cpc + 32'd4;
      2'b01:   e.pc = tk ? m_cpc + 32'd4 + m_off * 32'd4 : m_cpc + 32'd4;
      2'b10:   e.pc = m_abs;
      default: e.pc = m_cpc;
    endcase
    e.pinc = m_pi;
    return e;
  endfunction

  task automatic drive(input logic [3:0] d_op, input logic [31:0] d_a, d_b,
                       input logic [1:0] d_bc, input logic [31:0] d_cpc,
                       input logic [1:0] d_pi, input logic [31:0] d_abs, d_off);
    op = d_op; a = d_a; b = d_b; branch_cond = d_bc;
    current_pc = d_cpc; pc_inc = d_pi; abs_addr = d_abs; branch_addr = d_off;
  endtask

  task automatic push_exp(input logic [31:0] r, input logic z, input logic o,
                          input logic [31:0] p, input logic [1:0] pi);
    exp_t e;
    e.res = r; e.zero = z; e.ovf = o; e.pc = p; e.pinc = pi;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    clr = 1'b1;
    drive(OP_ADD, 32'h1234_5678, 32'h1, BR_NE, 32'h400, PC_JUMP, 32'hDEAD_BEEC, 32'h5);
    push_exp(32'd0, 1'b0, 1'b0, RST_PC, 2'b00);
    @(posedge clk); #1;
    e = sb.pop_front();
    n_run++;
    if ({alu_result, alu_zero, alu_ovf, next_pc, pc_inc_q} !== e) begin
      n_fail++;
      $display("FAIL reset: got res=%h z=%b o=%b pc=%h pi=%b, expected res=%h z=%b o=%b pc=%h pi=%b",
               alu_result, alu_zero, alu_ovf, next_pc, pc_inc_q, e.res, e.zero, e.ovf, e.pc, e.pinc);
    end
    clr = 1'b0;
  endtask

  // Directed vectors with hand-computed expectations.
  task automatic test_directed();
    exp_t  e;
    string nm;
    for (int i = 0; i < 13; i++) begin
      case (i)
        0:  begin nm = "beq_taken";   drive(OP_SUB, 5, 5, BR_EQ, 32'h100, PC_BRANCH, 0, 32'hFFFF_FFFE); push_exp(0, 1, 0, 32'hFC, 2'b01); end
        1:  begin nm = "bne_taken";   drive(OP_SUB, 5, 4, BR_NE, 32'h100, PC_BRANCH, 0, 32'hFFFF_FFFE); push_exp(1, 0, 0, 32'hFC, 2'b01); end
        2:  begin nm = "beq_not";     drive(OP_SUB, 5, 4, BR_EQ, 32'h100, PC_BRANCH, 0, 32'hFFFF_FFFE); push_exp(1, 0, 0, 32'h104, 2'b01); end
        3:  begin nm = "sra";         drive(OP_SRA, 32'h8000_0000, 4, BR_NONE, 0, PC_SEQ, 0, 0); push_exp(32'hF800_0000, 0, 0, 32'h4, 2'b00); end
        4:  begin nm = "slt";         drive(OP_SLT, 32'hFFFF_FFFF, 1, BR_NONE, 0, PC_SEQ, 0, 0); push_exp(1, 0, 0, 32'h4, 2'b00); end
        5:  begin nm = "sltu";        drive(OP_SLTU, 32'hFFFF_FFFF, 1, BR_NONE, 0, PC_SEQ, 0, 0); push_exp(0, 1, 0, 32'h4, 2'b00); end
        6:  begin nm = "jump";        drive(OP_AND, 0, 0, BR_EQ, 32'h80, PC_JUMP, 32'h0040_0020, 8); push_exp(0, 1, 0, 32'h0040_0020, 2'b10); end
        7:  begin nm = "stop";        drive(OP_OR, 32'h3, 0, BR_NE, 32'h200, PC_STOP, 32'h1000, 8); push_exp(3, 0, 0, 32'h200, 2'b11); end
        8:  begin nm = "add_ovf_wrap"; drive(OP_ADD, 32'h7FFF_FFFF, 1, BR_NONE, 32'hFFFF_FFFC, PC_SEQ, 0, 0); push_exp(32'h8000_0000, 0, OVF_ON, 0, 2'b00); end
        9:  begin nm = "sub_ovf";     drive(OP_SUB, 32'h8000_0000, 1, BR_NONE, 32'h10, PC_SEQ, 0, 0); push_exp(32'h7FFF_FFFF, 0, OVF_ON, 32'h14, 2'b00); end
        10: begin nm = "bc_ignored";  drive(OP_XOR, 32'hA5, 32'hA5, BR_EQ, 32'h300, PC_SEQ, 0, 32'h100); push_exp(0, 1, 0, 32'h304, 2'b00); end
        11: begin nm = "op_unused";   drive(4'd13, 32'hFFFF, 32'h1, BR_NONE, 32'h40, PC_SEQ, 0, 0); push_exp(0, 1, 0, 32'h44, 2'b00); end
        default: begin nm = "lui_fwd_branch"; drive(OP_LUI, 32'h0, 32'h0001_ABCD, BR_NE, 32'h20, PC_BRANCH, 0, 32'h3); push_exp(32'hABCD_0000, 0, 0, 32'h30, 2'b01); end
      endcase
      @(posedge clk); #1;
      e = sb.pop_front();
      n_run++;
      if ({alu_result, alu_zero, alu_ovf, next_pc, pc_inc_q} !== e) begin
        n_fail++;
        $display("FAIL %s: got res=%h z=%b o=%b pc=%h pi=%b, expected res=%h z=%b o=%b pc=%h pi=%b",
                 nm, alu_result, alu_zero, alu_ovf, next_pc, pc_inc_q, e.res, e.zero, e.ovf, e.pc, e.pinc);
      end
    end
  endtask

  // New random operation every cycle, checked against the reference model.
  task automatic test_back_to_back(input int cycles);
    exp_t        e;
    logic [31:0] ra, rb;
    logic [3:0]  rop;
    for (int i = 0; i < cycles; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom();
      rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom();
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 40));
      drive(rop, ra, rb, 2'($urandom_range(0, 3)), $urandom() & 32'hFFFF_FFFC,
            2'($urandom_range(0, 3)), $urandom(), $urandom());
      sb.push_back(model(op, a, b, branch_cond, current_pc, pc_inc, abs_addr, branch_addr));
      @(posedge clk); #1;
      e = sb.pop_front();
      n_run++;
      if ({alu_result, alu_zero, alu_ovf, next_pc, pc_inc_q} !== e) begin
        n_fail++;
        $display("FAIL b2b[%0d] op=%0d: got res=%h z=%b o=%b pc=%h pi=%b, expected res=%h z=%b o=%b pc=%h pi=%b",
                 i, rop, alu_result, alu_zero, alu_ovf, next_pc, pc_inc_q, e.res, e.zero, e.ovf, e.pc, e.pinc);
      end
    end
  endtask

  // clr for one edge in the middle of traffic, then capture resumes.
  task automatic test_midstream_clr();
    exp_t e;
    test_back_to_back(3);
    clr = 1'b1;
    drive(OP_NOR, 32'h0, 32'h0, BR_NE, 32'h500, PC_JUMP, 32'h8888_0000, 1);
    push_exp(32'd0, 1'b0, 1'b0, RST_PC, 2'b00);
    @(posedge clk); #1;
    clr = 1'b0;
    drive(OP_ADD, 32'h10, 32'h20, BR_NONE, 32'h600, PC_BRANCH, 0, 32'h7);
    push_exp(32'h30, 0, 0, 32'h604, 2'b01);
    for (int k = 0; k < 2; k++) begin
      e = sb.pop_front();
      n_run++;
      if ({alu_result, alu_zero, alu_ovf, next_pc, pc_inc_q} !== e) begin
        n_fail++;
        $display("FAIL midstream_clr[%0d]: got res=%h z=%b o=%b pc=%h pi=%b, expected res=%h z=%b o=%b pc=%h pi=%b",
                 k, alu_result, alu_zero, alu_ovf, next_pc, pc_inc_q, e.res, e.zero, e.ovf, e.pc, e.pinc);
      end
      if (k == 0) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    clr = 1'b1;
    drive(OP_ADD, 0, 0, BR_NONE, 0, PC_SEQ, 0, 0);
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_back_to_back(60);
    test_midstream_clr();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pc_unit.md
ALU_PC_UNIT -- requirements
Module: alu_pc_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, value loaded into next_pc on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 clr  input  1  reset, synchronous, active-high.
REQ-004 op  input  4  ALU operation code.
REQ-005 a, b  input  32 each  ALU operands.
REQ-006 branch_cond  input  2  00 none, 01 BEQ (take if zero), 10 BNE (take if not zero), 11 none.
REQ-007 current_pc  input  32  PC of the instruction in flight.
REQ-008 pc_inc  input  2  00 sequential, 01 branch, 10 jump, 11 stop.
REQ-009 abs_addr  input  32  jump target, byte address.
REQ-010 branch_addr  input  32  sign-extended word offset.
REQ-011 alu_result  output  32  registered ALU result.
REQ-012 alu_zero  output  1  registered; 1 iff the ALU result is 32'h0.
REQ-013 alu_ovf  output  1  registered signed-overflow flag (see REQ-030).
REQ-014 next_pc  output  32  registered next PC.
REQ-015 pc_inc_q  output  2  registered copy of pc_inc.

Function
REQ-016 ALU ops: 0 ADD a+b, 1 SUB a-b, 2 AND, 3 OR, 4 XOR, 5 NOR; all modulo 2^32.
REQ-017 Further ALU ops: 6 SLT signed a<b gives 1 else 0, 7 SLTU unsigned a<b, 8 SLL a<<b[4:0], 9 SRL a>>b[4:0] logical.
REQ-018 Op 10 SRA: a>>>b[4:0] arithmetic, with a as the shifted value and b[4:0] the shift amount for all shifts.
REQ-019 Op 11 LUI: result {b[15:0],16'h0}; ops 12-15 give result 0.
REQ-020 Branch taken = (branch_cond==BEQ && combinational zero) || (branch_cond==BNE && !combinational zero).
REQ-021 pc_inc 00: next_pc = current_pc+4.
REQ-022 pc_inc 01: next_pc = current_pc+4+(branch_addr<<2) if taken, else current_pc+4.
REQ-023 pc_inc 10: next_pc = abs_addr; pc_inc 11 (stop): next_pc = current_pc.
REQ-024 All PC arithmetic modulo 2^32: 32'hFFFF_FFFC+4 yields 0; negative offsets wrap.
REQ-025 Latency one cycle: inputs sampled at edge N appear on outputs after edge N; no handshake; a new operation every cycle.
REQ-026 branch_cond is ignored unless pc_inc==01.

Reset
REQ-027 clr high at a rising edge: alu_result=0, alu_zero=0, alu_ovf=0, next_pc=RESET_PC, pc_inc_q=00.
REQ-028 clr takes priority over any input activity in that cycle, including mid-stream.
REQ-029 Normal capture resumes on the first edge with clr low.

Configuration
REQ-030 Macro ALU_OVF_EN defined: alu_ovf=1 when ADD/SUB signed overflow occurs, else 0; results still wrap.
REQ-031 Macro ALU_OVF_EN undefined: no overflow logic is built and alu_ovf is constant 0; the port is always present.

Structure
REQ-032 Package alu_pc_pkg holds the ALU op enum, the pc_inc enum, the branch_cond enum and constant PC_STEP=4.
REQ-033 One sub-module, alu_core: combinational ALU (op, a, b -> result, zero, ovf); PC logic and registers live in alu_pc_unit.

Verification
REQ-034 op=SUB, a=5, b=5, branch_cond=BEQ, pc_inc=01, current_pc=0x100, branch_addr=0xFFFF_FFFE -> alu_result=0, alu_zero=1, next_pc=0xFC.
REQ-035 Same as REQ-034 but b=4, branch_cond=BNE -> alu_result=1, alu_zero=0, next_pc=0xFC; with branch_cond=BEQ -> next_pc=0x104.
REQ-036 op=SRA, a=0x8000_0000, b=4 -> 0xF800_0000; op=SLT, a=0xFFFF_FFFF, b=1 -> 1; op=SLTU, same operands -> 0.
REQ-037 pc_inc=10, abs_addr=0x0040_0020 -> next_pc=0x0040_0020; pc_inc=11, current_pc=0x200 -> next_pc=0x200, pc_inc_q=11.
REQ-038 op=ADD, a=0x7FFF_FFFF, b=1 -> alu_result=0x8000_0000, alu_ovf=1 with ALU_OVF_EN, 0 without; current_pc=0xFFFF_FFFC, pc_inc=00 -> next_pc=0.
REQ-039 clr asserted for one edge after non-zero traffic -> all outputs at reset values (next_pc=RESET_PC) the following cycle.
